// File: rtl/alu_share_arb_if.sv
// Requester, ALU-side and response signals of the shared-ALU arbiter.
// slave = arbiter side, master = requesters / ALU / response consumer side.
interface alu_share_arb_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_func;
  logic [3:0] req0_a;
  logic [3:0] req0_b;

  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_func;
  logic [3:0] req1_a;
  logic [3:0] req1_b;

  logic [2:0] alu_func;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_result;
  logic       alu_c;
  logic       alu_over;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_c;
  logic       rsp_over;

  modport slave (
    input  req0_valid, req0_func, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_func, req1_a, req1_b,
    output req1_ready,
    output alu_func, alu_a, alu_b,
    input  alu_result, alu_c, alu_over,
    output rsp_valid, rsp_id, rsp_result, rsp_c, rsp_over,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_func, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_func, req1_a, req1_b,
    input  req1_ready,
    input  alu_func, alu_a, alu_b,
    output alu_result, alu_c, alu_over,
    input  rsp_valid, rsp_id, rsp_result, rsp_c, rsp_over,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester arbiter/sequencer for the shared 4-bit ALU: grant, register
// operands, capture the ALU outputs one cycle later, return a tagged response.
module alu_share_arb #(
  parameter bit          RR_EN = 1'b1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arb_if.slave   bus,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   gnt0;
  logic   gnt1;

  // Ready is combinational and only offered in IDLE; tie break by last_grant
  // when round-robin, otherwise requester 0 always wins.
  always_comb begin
    gnt0 = '0;
    gnt1 = '0;
    if (state == IDLE && rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (RR_EN && !last_grant) gnt1 = '1;
        else                      gnt0 = '1;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      last_grant     <= '1;
      bus.alu_func   <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_id     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_c      <= '0;
      bus.rsp_over   <= '0;
      grant_cnt0     <= '0;
      grant_cnt1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            bus.alu_func <= gnt1 ? bus.req1_func : bus.req0_func;
            bus.alu_a    <= gnt1 ? bus.req1_a    : bus.req0_a;
            bus.alu_b    <= gnt1 ? bus.req1_b    : bus.req0_b;
            last_grant   <= gnt1;
            state        <= EXEC;
            if (gnt0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (gnt1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
          end
        end
        EXEC: begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp_c      <= bus.alu_c;
          bus.rsp_over   <= bus.alu_over;
          bus.rsp_id     <= last_grant;
          bus.rsp_valid  <= '1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: round-robin and fixed-priority instances
// driven by a behavioural ALU; responses checked against a grant model.
module tb_alu_share_arb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arb_if rif ();
  alu_share_arb_if fif ();
  logic [7:0] rr_cnt0, rr_cnt1, fp_cnt0, fp_cnt1;

  alu_share_arb #(.RR_EN(1'b1), .CNT_W(8)) u_rr (
    .clk(clk), .rst(rst), .bus(rif.slave), .grant_cnt0(rr_cnt0), .grant_cnt1(rr_cnt1));
  alu_share_arb #(.RR_EN(1'b0), .CNT_W(8)) u_fp (
    .clk(clk), .rst(rst), .bus(fif.slave), .grant_cnt0(fp_cnt0), .grant_cnt1(fp_cnt1));

  // {carry, overflow, result}
  function automatic logic [5:0] alu_model(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [5:0] r;
    r = '0;
    case (f)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = {s[4], (a[3] == b[3]) && (s[3] != a[3]), s[3:0]}; end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = {s[4], (a[3] != b[3]) && (s[3] != a[3]), s[3:0]}; end
      3'd2: r = {2'b00, ~a};
      3'd3: r = {2'b00, a & b};
      3'd4: r = {2'b00, a | b};
      3'd5: r = {2'b00, a ^ b};
      3'd6: r = {2'b00, 3'b000, a < b};
      default: r = {2'b00, 3'b000, a == b};
    endcase
    return r;
  endfunction

  assign {rif.alu_c, rif.alu_over, rif.alu_result} = alu_model(rif.alu_func, rif.alu_a, rif.alu_b);
  assign {fif.alu_c, fif.alu_over, fif.alu_result} = alu_model(fif.alu_func, fif.alu_a, fif.alu_b);

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        id;
    logic [2:0]  f;
    logic [3:0]  a;
    logic [3:0]  b;
    int unsigned acc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  logic        m_last = 1'b1;
  logic        m_busy = 1'b0;
  logic        m_prev = 1'b0;

  // Grant/response model for the round-robin instance.
  always @(negedge clk) begin
    exp_t       e;
    logic       e0, e1;
    logic [5:0] r;
    cyc++;
    if (!rst) begin
      m_last = 1'b1;
      m_busy = 1'b0;
      m_prev = 1'b0;
      sbq.delete();
    end else if (m_busy) begin
      chk("busy_rdy0", rif.req0_ready, 0);
      chk("busy_rdy1", rif.req1_ready, 0);
      e = sbq[0];
      if (cyc == e.acc + 1) begin
        chk("alu_func", rif.alu_func, e.f);
        chk("alu_a", rif.alu_a, e.a);
        chk("alu_b", rif.alu_b, e.b);
        chk("exec_vld", rif.rsp_valid, 0);
      end
      if (rif.rsp_valid && !m_prev) chk("rsp_lat", cyc - e.acc, 2);
      if (rif.rsp_valid && rif.rsp_ready) begin
        e = sbq.pop_front();
        r = alu_model(e.f, e.a, e.b);
        chk("rsp_id", rif.rsp_id, e.id);
        chk("rsp_result", rif.rsp_result, r[3:0]);
        chk("rsp_over", rif.rsp_over, r[4]);
        chk("rsp_c", rif.rsp_c, r[5]);
        m_busy = 1'b0;
      end
      m_prev = rif.rsp_valid;
    end else begin
      e0 = rif.req0_valid && (!rif.req1_valid || m_last);
      e1 = rif.req1_valid && (!rif.req0_valid || !m_last);
      chk("rdy0", rif.req0_ready, e0);
      chk("rdy1", rif.req1_ready, e1);
      chk("idle_rsp", rif.rsp_valid, 0);
      if (e0 || e1) begin
        e.id  = e1;
        e.f   = e1 ? rif.req1_func : rif.req0_func;
        e.a   = e1 ? rif.req1_a    : rif.req0_a;
        e.b   = e1 ? rif.req1_b    : rif.req0_b;
        e.acc = cyc;
        sbq.push_back(e);
        m_last = e1;
        m_busy = 1'b1;
        m_prev = 1'b0;
      end
    end
  end

  int unsigned fp_r1_seen = 0;
  int unsigned fp_id1 = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (fif.req1_ready) fp_r1_seen++;
      if (fif.rsp_valid && fif.rsp_ready && fif.rsp_id) fp_id1++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_acc(input int r, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((r == 0 && rif.req0_ready) || (r == 1 && rif.req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          gid[4];
    int          gcy[4];
    int unsigned n;
    logic        ok;

    rst = 1'b0;
    {rif.req0_valid, rif.req0_func, rif.req0_a, rif.req0_b} = '0;
    {rif.req1_valid, rif.req1_func, rif.req1_a, rif.req1_b} = '0;
    {fif.req0_valid, fif.req0_func, fif.req0_a, fif.req0_b} = '0;
    {fif.req1_valid, fif.req1_func, fif.req1_a, fif.req1_b} = '0;
    rif.rsp_ready = 1'b1;
    fif.rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_rdy0", rif.req0_ready, 0);
    chk("rst_rdy1", rif.req1_ready, 0);
    chk("rst_alu", {rif.alu_func, rif.alu_a, rif.alu_b}, 0);
    chk("rst_rsp", {rif.rsp_valid, rif.rsp_id, rif.rsp_result, rif.rsp_c, rif.rsp_over}, 0);
    chk("rst_cnt", {rr_cnt0, rr_cnt1}, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Single op: AND 1100 & 1010
    @(posedge clk); #1;
    rif.req0_valid = 1'b1; rif.req0_func = 3'd3; rif.req0_a = 4'b1100; rif.req0_b = 4'b1010;
    @(negedge clk);
    chk("t1_rdy0", rif.req0_ready, 1);
    chk("t1_rdy1", rif.req1_ready, 0);
    @(posedge clk); #1 rif.req0_valid = 1'b0;
    chk("t1_alu", {rif.alu_func, rif.alu_a, rif.alu_b}, {3'd3, 4'b1100, 4'b1010});
    @(negedge clk);
    chk("t1_exec_vld", rif.rsp_valid, 0);
    @(negedge clk);
    chk("t1_vld", rif.rsp_valid, 1);
    chk("t1_id", rif.rsp_id, 0);
    chk("t1_res", rif.rsp_result, 4'b1000);
    chk("t1_c", rif.rsp_c, 0);
    chk("t1_over", rif.rsp_over, 0);
    repeat (2) @(negedge clk);

    // Round-robin, both valid continuously
    do_reset();
    rif.req0_func = 3'd0; rif.req0_a = 4'd3; rif.req0_b = 4'd5;
    rif.req1_func = 3'd1; rif.req1_a = 4'd2; rif.req1_b = 4'd7;
    rif.req0_valid = 1'b1; rif.req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin gid[k] = 9; gcy[k] = 0; end
    n = 0;
    for (int i = 0; i < 14 && n < 4; i++) begin
      @(negedge clk);
      if (rif.req0_ready) begin gid[n] = 0; gcy[n] = i; n++; end
      else if (rif.req1_ready) begin gid[n] = 1; gcy[n] = i; n++; end
    end
    @(posedge clk); #1 rif.req0_valid = 1'b0; rif.req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rr_n", n, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_gid%0d", k), gid[k], k % 2);
    for (int k = 1; k < 4; k++) chk($sformatf("rr_gap%0d", k), gcy[k] - gcy[k-1], 3);
    chk("rr_cnt0", rr_cnt0, 2);
    chk("rr_cnt1", rr_cnt1, 2);

    // Fixed priority on the second instance
    do_reset();
    fp_r1_seen = 0; fp_id1 = 0;
    fif.req0_func = 3'd4; fif.req0_a = 4'd1; fif.req0_b = 4'd8;
    fif.req1_func = 3'd5; fif.req1_a = 4'd3; fif.req1_b = 4'd6;
    fif.req0_valid = 1'b1; fif.req1_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fif.req0_ready) n++;
    end
    @(posedge clk); #1 fif.req0_valid = 1'b0; fif.req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("fp_acc0", n, 4);
    chk("fp_r1_seen", fp_r1_seen, 0);
    chk("fp_id1", fp_id1, 0);
    chk("fp_cnt0", fp_cnt0, 4);
    chk("fp_cnt1", fp_cnt1, 0);

    // Backpressure: XOR 0110 ^ 0011 from requester 1
    @(posedge clk); #1;
    rif.rsp_ready = 1'b0;
    rif.req1_valid = 1'b1; rif.req1_func = 3'd5; rif.req1_a = 4'b0110; rif.req1_b = 4'b0011;
    wait_acc(1, ok);
    chk("bp_acc", ok, 1);
    @(posedge clk); #1;
    rif.req1_valid = 1'b0;
    rif.req0_valid = 1'b1; rif.req0_func = 3'd2; rif.req0_a = 4'd9; rif.req0_b = 4'd0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", rif.rsp_valid, 1);
      chk("bp_res", rif.rsp_result, 4'b0101);
      chk("bp_id", rif.rsp_id, 1);
      chk("bp_rdy", {rif.req0_ready, rif.req1_ready}, 0);
    end
    @(posedge clk); #1 rif.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy0", rif.req0_ready, 0);
    @(negedge clk);
    chk("bp_idle_rdy0", rif.req0_ready, 1);
    @(posedge clk); #1 rif.req0_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Saturation: 300 requester-0 ops
    do_reset();
    rif.req0_valid = 1'b1; rif.req0_func = 3'd6; rif.req0_a = 4'd1; rif.req0_b = 4'd2;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rif.req0_ready) n++;
      if (n == 300) break;
    end
    @(posedge clk); #1 rif.req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("sat_n", n, 300);
    chk("sat_cnt0", rr_cnt0, 255);
    chk("sat_cnt1", rr_cnt1, 0);

    // Reset while in EXEC
    do_reset();
    rif.req0_valid = 1'b1; rif.req0_func = 3'd0; rif.req0_a = 4'd7; rif.req0_b = 4'd7;
    @(negedge clk);
    chk("rx_rdy0", rif.req0_ready, 1);
    @(posedge clk); #1 rif.req0_valid = 1'b0;
    chk("rx_alu_pre", rif.alu_a, 4'd7);
    #2 rst = 1'b0;
    #1;
    chk("rx_vld", rif.rsp_valid, 0);
    chk("rx_alu", rif.alu_a, 0);
    chk("rx_cnt0", rr_cnt0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rx_norsp", rif.rsp_valid, 0);
    end
    @(posedge clk); #1;
    rif.req0_valid = 1'b1; rif.req1_valid = 1'b1;
    @(negedge clk);
    chk("rx_tie_rdy0", rif.req0_ready, 1);
    chk("rx_tie_rdy1", rif.req1_ready, 0);
    @(posedge clk); #1 rif.req0_valid = 1'b0; rif.req1_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the team's combinational 4-bit ALU (func 0–7: add, sub, not, and, or, xor, less-than, equal). It accepts operations from two independent requesters over valid/ready handshakes and grants the ALU round-robin or by fixed priority. It presents registered operands to the ALU, captures result/carry/overflow one cycle later and returns them tagged with the requester ID through a single response handshake. It sits between the instruction/test front-ends and the ALU instance.

## Interface
- RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins
- CNT_W, 8, width of the per-requester saturating grant counters
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (low = reset asserted)
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_func / req1_func  in  3  ALU function code
- req0_a, req0_b / req1_a, req1_b  in  4  operands
- alu_func  out  3  registered function to ALU
- alu_a, alu_b  out  4  registered operands to ALU
- alu_result  in  4  ALU result
- alu_c, alu_over  in  1  ALU carry and overflow
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  4  captured result
- rsp_c, rsp_over  out  1  captured carry and overflow
- grant_cnt0 / grant_cnt1  out  CNT_W  accepted operations per requester, saturating

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE, no valid: stay in IDLE, both readys 0.
- IDLE, any valid:
  - pick grantee g; reqg_ready = 1 (combinational, only in IDLE); the other ready = 0.
  - Latch func/a/b into alu_*; set last_grant = g; go to EXEC.
- Grant rule, only one valid: that requester wins.
- Grant rule, both valid, RR_EN=1: the requester != last_grant wins.
- Grant rule, both valid, RR_EN=0: requester 0 wins.
- EXEC: capture alu_result/alu_c/alu_over into rsp_*; rsp_id = last_grant; rsp_valid = 1; go to RESP.
- RESP:
  - hold all rsp_* stable while rsp_ready = 0.
  - On rsp_ready = 1: clear rsp_valid and go to IDLE. No new accept in that cycle.
- alu_* outputs hold their last value outside IDLE accepts; they change only on an accept.
- All func codes 0–7 are forwarded unchanged. The block does no decoding and no arithmetic on the data.
- Grant counters: increment on that requester's accept; saturate at 2^CNT_W-1; never wrap.
- A requester not granted keeps valid asserted. Its inputs are not sampled until it is granted.

## Timing
- Accept in cycle T (valid & ready high at edge T): alu_* valid after edge T.
- rsp_valid high after edge T+1, i.e. response visible in cycle T+2.
- rsp_ready high in cycle T+2 frees the block; the next accept is possible in cycle T+3. Peak throughput is 1 op per 3 cycles.
- Reset values:
  - state IDLE
  - req*_ready 0
  - alu_func/alu_a/alu_b 0
  - rsp_valid 0; rsp_id/rsp_result/rsp_c/rsp_over 0
  - last_grant 1, so requester 0 wins the first tie
  - grant counters 0
- Reset asserted mid-operation (EXEC or RESP): the in-flight operation is dropped with no response. All registers return to reset values immediately (asynchronous). Operation restarts in IDLE on the first edge after rst deasserts.
- rsp_ready is ignored outside RESP.

## Test plan
- Single op: req0 func=3 a=4'b1100 b=4'b1010 at T -> req0_ready=1 at T; rsp_valid at T+2 with rsp_id=0, rsp_result=4'b1000, rsp_c=0, rsp_over=0.
- Round-robin: both valid continuously, rsp_ready=1, RR_EN=1 -> grant order 0,1,0,1; accepts every 3 cycles; grant_cnt0=grant_cnt1=2 after 4 ops.
- Fixed priority: same stimulus with RR_EN=0 -> all four grants to requester 0; req1_ready never 1; grant_cnt1=0.
- Backpressure: req1 func=5 a=4'b0110 b=4'b0011; hold rsp_ready=0 for 5 cycles -> rsp_result=4'b0101 and rsp_id=1 stable; both readys 0 throughout; release -> IDLE next cycle.
- Saturation: CNT_W=8, 300 req0 ops -> grant_cnt0=255, grant_cnt1=0.
- Reset in EXEC: assert rst low in the cycle after an accept -> rsp_valid=0 immediately; no response after release; next tie is granted to requester 0.
